// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: synchronizes SCL/SDA, ACKs a matching write address and
// up to MAX_BYTES data bytes, and strobes each byte out. Option: I2C_GLITCH_FILTER_EN.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h27,
  parameter int         MAX_BYTES   = 3,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [1:0] rx_idx,
  output logic       busy,
  output logic       stop_det
);

  localparam int BCW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_p_q, sda_p_q;

  // Synchronizers reset to the idle-high bus level so reset release creates no edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
    end
  end

  assign scl_s = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[1] & scl_hist_q[2]) |
                 (scl_hist_q[0] & scl_hist_q[2]);
  assign sda_s = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[1] & sda_hist_q[2]) |
                 (sda_hist_q[0] & sda_hist_q[2]);
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign start_ev = scl_s & scl_p_q & ~sda_s & sda_p_q;
  assign stop_ev  = scl_s & scl_p_q & sda_s & ~sda_p_q;

  state_t           state_q;
  logic [2:0]       bit_cnt_q;
  logic [6:0]       shift_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic             sda_oe_q, rx_valid_q, busy_q, stop_det_q;
  logic [7:0]       rx_data_q;
  logic [1:0]       rx_idx_q;
  logic [7:0]       byte_d;

  assign byte_d = {shift_q, sda_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_idx_q   <= '0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      stop_det_q <= 1'b0;
      if (stop_ev) begin
        state_q    <= IDLE;
        bit_cnt_q  <= '0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        stop_det_q <= 1'b1;
      end else if (start_ev) begin
        state_q    <= ADDR;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        sda_oe_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (byte_d[7:1] == SLAVE_ADDR && !byte_d[0]) begin
                  state_q <= ADDR_ACK;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= IGNORE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          // First SCL fall (end of bit 8) grabs SDA, the next one (end of bit 9) lets go.
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= DATA;
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shift_q   <= byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (byte_cnt_q < BCW'(MAX_BYTES)) begin
                  rx_data_q  <= byte_d;
                  rx_valid_q <= 1'b1;
                  rx_idx_q   <= 2'(byte_cnt_q);
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  state_q    <= DATA_ACK;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end
          IGNORE: sda_oe_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_idx   = rx_idx_q;
  assign busy     = busy_q;
  assign stop_det = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: bit-banged I2C writes on an open-drain SDA model.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] rx_idx;
  logic       busy;
  logic       stop_det;

  int checks = 0;
  int failures = 0;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_m),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_idx   (rx_idx),
    .busy     (busy),
    .stop_det (stop_det)
  );

  // Bus monitor sampled on the falling clock edge.
  logic       mon_clr = 1'b0;
  logic [7:0] rxd [8];
  logic [1:0] rxi [8];
  int rx_cnt = 0, stop_cnt = 0, oe_rise = 0, both_cnt = 0, busy_seen = 0;
  logic oe_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      rx_cnt = 0; stop_cnt = 0; oe_rise = 0; busy_seen = 0;
    end else begin
      if (rx_valid) begin
        if (rx_cnt < 8) begin
          rxd[rx_cnt] = rx_data;
          rxi[rx_cnt] = rx_idx;
        end
        rx_cnt++;
      end
      if (stop_det) stop_cnt++;
      if (sda_oe && !oe_prev) oe_rise++;
      if (busy) busy_seen = 1;
      if (rx_valid && stop_det) both_cnt++;
    end
    oe_prev = sda_oe;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(2*Q);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(Q);   sda_m = b;
    wait_clk(Q);   scl_m = 1'b1;
    wait_clk(2*Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q);
    @(negedge clk);
    ack = (sda_oe === 1'b1) && (sda_in === 1'b0);
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    checks++;
    if ({sda_oe, rx_valid, busy, stop_det} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got oe/valid/busy/stop=%b expected 0000",
               {sda_oe, rx_valid, busy, stop_det});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_rx_data got %h expected 00", rx_data);
    end
    checks++;
    if (rx_idx !== 2'd0) begin
      failures++; $display("FAIL reset_rx_idx got %0d expected 0", rx_idx);
    end
    rst_n = 1'b1;
    wait_clk(10);
    @(negedge clk);
    checks++;
    if ({sda_oe, rx_valid, busy, stop_det} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_after_reset got %b expected 0000", {sda_oe, rx_valid, busy, stop_det});
    end
  endtask

  task automatic test_write3();
    logic ack;
    logic [7:0] dat [3];
    dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'hFF;
    clear_mon();
    i2c_start();
    send_byte(8'h4E, ack);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL w3_addr_ack got %b expected 1", ack); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL w3_busy got %b expected 1", busy); end
    for (int i = 0; i < 3; i++) begin
      send_byte(dat[i], ack);
      checks++;
      if (ack !== 1'b1) begin failures++; $display("FAIL w3_data_ack%0d got %b expected 1", i, ack); end
    end
    i2c_stop();
    checks++;
    if (rx_cnt !== 3) begin failures++; $display("FAIL w3_rx_count got %0d expected 3", rx_cnt); end
    for (int i = 0; i < 3 && i < rx_cnt; i++) begin
      checks++;
      if (rxd[i] !== dat[i] || rxi[i] !== 2'(i)) begin
        failures++;
        $display("FAIL w3_byte%0d got (%0d,%h) expected (%0d,%h)", i, rxi[i], rxd[i], i, dat[i]);
      end
    end
    checks++;
    if (oe_rise !== 4) begin failures++; $display("FAIL w3_ack_pulses got %0d expected 4", oe_rise); end
    checks++;
    if (stop_cnt !== 1) begin failures++; $display("FAIL w3_stop_count got %0d expected 1", stop_cnt); end
    checks++;
    if (busy !== 1'b0 || sda_oe !== 1'b0) begin
      failures++; $display("FAIL w3_after_stop busy/oe got %b%b expected 00", busy, sda_oe);
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    clear_mon();
    i2c_start();
    send_byte(8'h50, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL mm_addr_ack got %b expected 0", ack); end
    send_byte(8'h11, ack);
    i2c_stop();
    checks++;
    if (oe_rise !== 0) begin failures++; $display("FAIL mm_oe_pulses got %0d expected 0", oe_rise); end
    checks++;
    if (rx_cnt !== 0) begin failures++; $display("FAIL mm_rx_count got %0d expected 0", rx_cnt); end
    checks++;
    if (busy_seen !== 0) begin failures++; $display("FAIL mm_busy_seen got %0d expected 0", busy_seen); end
  endtask

  task automatic test_read();
    logic ack;
    clear_mon();
    i2c_start();
    send_byte(8'h4F, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL rd_addr_ack got %b expected 0", ack); end
    send_byte(8'h00, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL rd_ignore_ack got %b expected 0", ack); end
    i2c_stop();
    checks++;
    if (rx_cnt !== 0 || stop_cnt !== 1) begin
      failures++; $display("FAIL rd_counts got rx=%0d stop=%0d expected rx=0 stop=1", rx_cnt, stop_cnt);
    end
  endtask

  task automatic test_overflow();
    logic ack;
    logic [3:0] acks;
    clear_mon();
    i2c_start();
    send_byte(8'h4E, ack);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(i + 1), ack);
      acks[i] = ack;
    end
    i2c_stop();
    checks++;
    if (acks !== 4'b0111) begin failures++; $display("FAIL ov_acks got %b expected 0111", acks); end
    checks++;
    if (rx_cnt !== 3) begin failures++; $display("FAIL ov_rx_count got %0d expected 3", rx_cnt); end
    checks++;
    if (rx_data !== 8'h03 || rx_idx !== 2'd2) begin
      failures++; $display("FAIL ov_last_byte got (%0d,%h) expected (2,03)", rx_idx, rx_data);
    end
  endtask

  task automatic test_abort();
    logic ack;
    clear_mon();
    i2c_start();
    send_byte(8'h4E, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_start();
    checks++;
    if (rx_cnt !== 0 || sda_oe !== 1'b0) begin
      failures++; $display("FAIL ab_partial got rx=%0d oe=%b expected rx=0 oe=0", rx_cnt, sda_oe);
    end
    send_byte(8'h4E, ack);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL ab_readdr_ack got %b expected 1", ack); end
`ifdef I2C_GLITCH_FILTER_EN
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(1);
    scl_m = 1'b0;
`endif
    send_byte(8'h77, ack);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL ab_data_ack got %b expected 1", ack); end
    i2c_stop();
    checks++;
    if (rx_cnt !== 1) begin
      failures++; $display("FAIL ab_rx_count got %0d expected 1", rx_cnt);
    end else begin
      checks++;
      if (rxd[0] !== 8'h77 || rxi[0] !== 2'd0) begin
        failures++; $display("FAIL ab_byte got (%0d,%h) expected (0,77)", rxi[0], rxd[0]);
      end
    end
    checks++;
    if (stop_cnt !== 1) begin failures++; $display("FAIL ab_stop_count got %0d expected 1", stop_cnt); end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (both_cnt !== 0) begin
      failures++; $display("FAIL valid_stop_overlap got %0d cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write3();
    test_mismatch();
    test_read();
    test_overflow();
    test_abort();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
